i_encoder: RTL and testbench

I_ENCODER -- requirements
Module: i_encoder

---
 rtl/i_encoder_pkg.sv | 65 ++++++
 rtl/enc_fifo2.sv | 41 ++++
 rtl/i_encoder.sv | 114 +++++++++++
 tb/tb_i_encoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i_encoder_pkg.sv
// Shared decode package for the instruction encoder.
// Holds the format/state encodings, opcode constants, the legality check and the word packer.
package i_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_J = 2'b01,
    FMT_R = 2'b10,
    FMT_X = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10
  } state_e;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_COP0    = 6'b010000;
  // upper five bits of the 00001x jump opcodes
  localparam logic [4:0] OPC_JUMP    = 5'b00001;

  typedef struct packed {
    fmt_e        fmt;
    logic [5:0]  opc;
    logic [5:0]  fun;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] iindex;
  } bundle_t;

  function automatic logic is_r_opc(logic [5:0] opc);
    return (opc == OPC_SPECIAL) || (opc == OPC_COP0);
  endfunction

  function automatic logic is_j_opc(logic [5:0] opc);
    return opc[5:1] == OPC_JUMP;
  endfunction

  function automatic logic is_illegal(bundle_t b);
    logic r;
    r = 1'b1;
    case (b.fmt)
      FMT_R:   r = !is_r_opc(b.opc);
      FMT_J:   r = !is_j_opc(b.opc);
      FMT_I:   r = is_r_opc(b.opc) || is_j_opc(b.opc);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] encode(bundle_t b);
    logic [31:0] w;
    case (b.fmt)
      FMT_R:   w = {b.opc, b.rs, b.rt, b.rd, b.sa, b.fun};
      FMT_J:   w = {b.opc, b.iindex};
      default: w = {b.opc, b.rs, b.rt, b.imm};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO; head is presented combinationally on dout.
// Push when full and pop when empty are ignored.
module enc_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && (count != 2'd2);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/i_encoder.sv
// Encodes R/I/J field bundles into 32-bit words with target addresses.
// Illegal bundles are dropped and flagged; a 2-deep FIFO decouples the writer.
module i_encoder
  import i_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_opc,
  input  logic [5:0]        in_fun,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_iindex,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err_illegal
);

  localparam int DW = 32 + ADDR_W;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              done_d;
  bundle_t           b;
  logic              bad;
  logic              accept;
  logic              push;
  logic              pop;
  logic [1:0]        count;
  logic [DW-1:0]     head;

  assign b = '{
    fmt:    fmt_e'(in_fmt),
    opc:    in_opc,
    fun:    in_fun,
    rs:     in_rs,
    rt:     in_rt,
    rd:     in_rd,
    sa:     in_sa,
    imm:    in_imm,
    iindex: in_iindex
  };

  assign bad       = is_illegal(b);
  assign in_ready  = (state_q == S_RUN) && (count != 2'd2);
  assign accept    = in_valid && in_ready;
  assign push      = accept && !bad;
  assign out_valid = count != 2'd0;
  assign pop       = out_valid && out_ready;
  assign busy      = state_q != S_IDLE;
  assign out_instr = out_valid ? head[DW-1 -: 32] : 32'd0;
  assign out_addr  = out_valid ? head[ADDR_W-1:0] : BASE;

  enc_fifo2 #(.W(DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({encode(b), addr_q}),
    .dout  (head),
    .count (count)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && in_last) state_d = S_DRAIN;
      S_DRAIN: begin
        // the FIFO empties on this edge, or already is
        if (count == 2'd0 || (count == 2'd1 && pop)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= BASE;
      done        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (state_q == S_IDLE && start) begin
        addr_q      <= BASE;
        err_illegal <= 1'b0;
      end
      if (push)         addr_q      <= addr_q + ADDR_W'(1);
      if (accept && bad) err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i_encoder.sv
// Directed bench for i_encoder with ADDR_W=2 so address wrap is reachable.
// Inputs driven and outputs sampled on the falling edge.
module tb_i_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_fmt = 2'd0;
  logic [5:0]    in_opc = 6'd0;
  logic [5:0]    in_fun = 6'd0;
  logic [4:0]    in_rs = 5'd0;
  logic [4:0]    in_rt = 5'd0;
  logic [4:0]    in_rd = 5'd0;
  logic [4:0]    in_sa = 5'd0;
  logic [15:0]   in_imm = 16'd0;
  logic [25:0]   in_iindex = 26'd0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;
  logic          err_illegal;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  i_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_fmt      (in_fmt),
    .in_opc      (in_opc),
    .in_fun      (in_fun),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_sa       (in_sa),
    .in_imm      (in_imm),
    .in_iindex   (in_iindex),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_addr    (out_addr),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] f, input logic [5:0] opc,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sa,
                       input logic [5:0] fun, input logic [15:0] imm,
                       input logic [25:0] ii, input logic last);
    in_fmt    = f;
    in_opc    = opc;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_sa     = sa;
    in_fun    = fun;
    in_imm    = imm;
    in_iindex = ii;
    in_last   = last;
    in_valid  = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_w;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    rst = 1'b0;

    // single R word, last
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    drive(2'b10, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_instr", out_instr, 32'h00221820);
    chk("t1_addr", 32'(out_addr), 32'd0);
    chk("t1_done_early", 32'(done), 32'd0);
    chk("t1_in_ready_drain", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_out_valid_end", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'd0);

    // backpressure: FIFO fills, then simultaneous push/pop
    out_ready = 1'b0;
    pulse_start();
    drive(2'b00, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0);
    @(negedge clk);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_instr0", out_instr, 32'h8FA80004);
    chk("t2_addr0", 32'(out_addr), 32'd0);
    chk("t2_ready1", 32'(in_ready), 32'd1);
    drive(2'b01, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000, 1'b0);
    @(negedge clk);
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_hold_instr", out_instr, 32'h8FA80004);
    drive(2'b10, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1);
    @(negedge clk);
    chk("t2_still_full", 32'(in_ready), 32'd0);
    chk("t2_stable_instr", out_instr, 32'h8FA80004);
    chk("t2_stable_addr", 32'(out_addr), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_instr1", out_instr, 32'h0C100000);
    chk("t2_addr1", 32'(out_addr), 32'd1);
    chk("t2_ready_again", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t2_instr2", out_instr, 32'h00221820);
    chk("t2_addr2", 32'(out_addr), 32'd2);
    chk("t2_drain_ready", 32'(in_ready), 32'd0);
    chk("t2_drain_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // illegal J opcode dropped, address not advanced
    pulse_start();
    drive(2'b01, 6'h08, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h1234, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_no_word", 32'(out_valid), 32'd0);
    chk("t3_err", 32'(err_illegal), 32'd1);
    chk("t3_addr_idle", 32'(out_addr), 32'd0);
    chk("t3_ready", 32'(in_ready), 32'd1);
    drive(2'b00, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_addr", 32'(out_addr), 32'd0);
    chk("t3_instr", out_instr, 32'h8FA80004);
    chk("t3_err_sticky", 32'(err_illegal), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_err_idle", 32'(err_illegal), 32'd1);
    out_ready = 1'b0;
    pulse_start();
    chk("t3_err_clr", 32'(err_illegal), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);

    // illegal last bundle still completes
    drive(2'b11, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_err", 32'(err_illegal), 32'd1);
    chk("t4_no_done", 32'(done), 32'd0);
    chk("t4_no_word", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_idle", 32'(busy), 32'd0);

    // address wrap with ADDR_W=2
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0,
            26'(i), (i == 4));
      @(negedge clk);
      exp_w = 32'h08000000 | 32'(i);
      chk("t5_addr", 32'(out_addr), 32'(i % 4));
      chk("t5_instr", out_instr, exp_w);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_done", 32'(done), 32'd1);

    // reset with two words queued
    out_ready = 1'b0;
    pulse_start();
    drive(2'b00, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0);
    @(negedge clk);
    drive(2'b01, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_queued", 32'(out_valid), 32'd1);
    chk("t6_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_instr", out_instr, 32'd0);
    chk("t6_rst_addr", 32'(out_addr), 32'd0);
    @(negedge clk);
    chk("t6_no_done", 32'(done), 32'd0);
    rst = 1'b0;
    pulse_start();
    drive(2'b10, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_restart_addr", 32'(out_addr), 32'd0);
    chk("t6_restart_instr", out_instr, 32'h00221820);
    @(negedge clk);
    chk("t6_done", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
